disp_subpixel_refine: RTL and testbench

//  Parabolic sub-pixel refinement of the winning disparity. Sits directly downstream of the

---
 rtl/disp_subpixel_refine.sv | 126 ++++++++++++
 tb/tb_disp_subpixel_refine.sv | 174 +++++++++++++++++
 2 files changed

// File: rtl/disp_subpixel_refine.sv
// Parabolic sub-pixel refinement of the winning disparity. It fits a parabola through C(d-1), C(d), C(d+1)
// and uses a pipelined restoring divider to produce one refined fixed-point disparity per clock.
module disp_subpixel_refine #(
  parameter int DATA_WIDTH = 8,
  parameter int POS_WIDTH  = 8,
  parameter int DIM_WIDTH  = 10,
  parameter int FRAC_BITS  = 4,
  parameter int MAX_DISP   = 64
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [DATA_WIDTH-1:0]          cost_lo,
  input  logic [DATA_WIDTH-1:0]          cost_mid,
  input  logic [DATA_WIDTH-1:0]          cost_hi,
  input  logic [POS_WIDTH-1:0]           pos_in,
  input  logic [DIM_WIDTH-1:0]           row_in,
  input  logic [DIM_WIDTH-1:0]           col_in,
  input  logic                           en,
  output logic [POS_WIDTH+FRAC_BITS-1:0] disp_out,
  output logic                           refined,
  output logic [DIM_WIDTH-1:0]           row_out,
  output logic [DIM_WIDTH-1:0]           col_out,
  output logic                           valid
);

  localparam int RW = DATA_WIDTH + 4;
  localparam int DW = POS_WIDTH + FRAC_BITS;
  localparam logic [FRAC_BITS-1:0] HALF = FRAC_BITS'(1) << (FRAC_BITS - 1);

  typedef struct packed {
    logic                  vld;
    logic [POS_WIDTH-1:0]  pos;
    logic [DIM_WIDTH-1:0]  row;
    logic [DIM_WIDTH-1:0]  col;
    logic                  sign;
    logic                  fallback;
    logic                  sat;
    logic [RW-1:0]         den;
    logic [RW-1:0]         rem;
    logic [FRAC_BITS-1:0]  q;
  } stage_t;

  // pipe[0] holds the set-up stage; pipe[i] has i quotient bits resolved.
  stage_t pipe [FRAC_BITS+1];

  logic signed [DATA_WIDTH:0]   num;
  logic signed [DATA_WIDTH+2:0] den;
  logic [DATA_WIDTH:0]          r0;
  logic                         fallback;
  stage_t                       s0;

  always_comb begin
    num      = $signed({1'b0, cost_lo}) - $signed({1'b0, cost_hi});
    den      = ($signed({3'b0, cost_lo}) + $signed({3'b0, cost_hi})
                - $signed({2'b0, cost_mid, 1'b0})) <<< 1;
    r0       = num[DATA_WIDTH] ? -num : num;
    // A flat or inverted parabola, or a d at the search edge, has no usable neighbours.
    fallback = (pos_in == '0) || (pos_in >= POS_WIDTH'(MAX_DISP - 1))
               || den[DATA_WIDTH+2] || (den == '0);
    s0          = '0;
    s0.vld      = en;
    s0.pos      = pos_in;
    s0.row      = row_in;
    s0.col      = col_in;
    s0.sign     = num[DATA_WIDTH];
    s0.fallback = fallback;
    s0.sat      = !fallback && ({3'b0, r0} >= {1'b0, den});
    s0.den      = {1'b0, den};
    s0.rem      = {3'b0, r0};
  end

  function automatic stage_t div_step(input stage_t s);
    stage_t        n;
    logic [RW-1:0] r2;
    logic          qbit;
    n    = s;
    r2   = {s.rem[RW-2:0], 1'b0};
    qbit = (r2 >= s.den);
    n.rem = qbit ? r2 - s.den : r2;
    n.q   = {s.q[FRAC_BITS-2:0], qbit};
    return n;
  endfunction

  stage_t                last;
  logic [FRAC_BITS-1:0]  q_lim;
  logic [DW-1:0]         q_ext;
  logic [DW-1:0]         disp_next;

  always_comb begin
    last      = pipe[FRAC_BITS];
    q_lim     = (last.sat || (last.q > HALF)) ? HALF : last.q;
    q_ext     = DW'(q_lim);
    disp_next = {last.pos, {FRAC_BITS{1'b0}}};
    if (!last.fallback)
      disp_next = disp_next + (last.sign ? -q_ext : q_ext);
  end

  // NOTE: every pipeline register, the stage array included, is reset so a mid-stream rst drops in-flight samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i <= FRAC_BITS; i++) pipe[i] <= '0;
      disp_out <= '0;
      refined  <= 1'b0;
      row_out  <= '0;
      col_out  <= '0;
      valid    <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments make each stage read its predecessor's previous-cycle value.
      pipe[0] <= s0;
      for (int i = 1; i <= FRAC_BITS; i++) pipe[i] <= div_step(pipe[i-1]);
      valid <= last.vld;
      if (last.vld) begin
        disp_out <= disp_next;
        refined  <= !last.fallback;
        row_out  <= last.row;
        col_out  <= last.col;
      end else begin
        disp_out <= '0;
        refined  <= 1'b0;
        row_out  <= '0;
        col_out  <= '0;
      end
    end
  end

endmodule

// File: tb/tb_disp_subpixel_refine.sv
// Self-checking bench for disp_subpixel_refine: directed vectors, a random gapped stream against a
// scoreboard of expected outputs, and a mid-stream reset.
module tb_disp_subpixel_refine;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  cost_lo, cost_mid, cost_hi, pos_in;
  logic [9:0]  row_in, col_in;
  logic        en;
  logic [11:0] disp_out;
  logic        refined;
  logic [9:0]  row_out, col_out;
  logic        valid;

  disp_subpixel_refine dut (
    .clk(clk), .rst(rst), .cost_lo(cost_lo), .cost_mid(cost_mid), .cost_hi(cost_hi),
    .pos_in(pos_in), .row_in(row_in), .col_in(col_in), .en(en),
    .disp_out(disp_out), .refined(refined), .row_out(row_out), .col_out(col_out), .valid(valid)
  );

  always #5 clk = ~clk;

  typedef struct {
    int disp;
    int ref_bit;
    int row;
    int col;
    int cyc;
  } exp_t;

  exp_t sb[$];
  int   cycle = 0;
  int   n_tests = 0;
  int   n_fail = 0;
  bit   mon_on = 1'b0;

  always @(posedge clk) cycle <= cycle + 1;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference: exact integer arithmetic, truncated magnitude, clamped to half a pixel.
  function automatic int model(input int lo, input int mid, input int hi, input int d, output int rf);
    int num, den, r0, q;
    num = lo - hi;
    den = 2 * (lo + hi - 2 * mid);
    if (d == 0 || d >= 63 || den <= 0) begin
      rf = 0;
      return d * 16;
    end
    rf = 1;
    r0 = (num < 0) ? -num : num;
    q  = (r0 >= den) ? 8 : (r0 * 16) / den;
    if (q > 8) q = 8;
    return d * 16 + ((num < 0) ? -q : q);
  endfunction

  task automatic send(input int lo, input int mid, input int hi, input int d,
                      input int r, input int c, input int edisp, input int eref);
    exp_t e;
    @(posedge clk); #1;
    en = 1'b1;
    cost_lo = lo[7:0]; cost_mid = mid[7:0]; cost_hi = hi[7:0];
    pos_in = d[7:0]; row_in = r[9:0]; col_in = c[9:0];
    e.disp = edisp; e.ref_bit = eref; e.row = r; e.col = c; e.cyc = cycle;
    sb.push_back(e);
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk); #1;
      en = 1'b0;
      cost_lo = 8'($urandom); cost_mid = 8'($urandom); cost_hi = 8'($urandom);
      pos_in = 8'($urandom); row_in = 10'($urandom); col_in = 10'($urandom);
    end
  endtask

  task automatic drain();
    int budget = 30;
    while (sb.size() != 0 && budget > 0) begin
      @(posedge clk); #1;
      en = 1'b0;
      budget--;
    end
    check("drain_pending", sb.size(), 0);
  endtask

  always @(negedge clk) begin
    if (mon_on) begin
      if (valid) begin
        if (sb.size() == 0) begin
          check("spurious_valid", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("disp_out", disp_out, e.disp);
          check("refined", refined, e.ref_bit);
          check("row_out", row_out, e.row);
          check("col_out", col_out, e.col);
          check("latency", cycle - e.cyc, 6);
        end
      end else begin
        check("idle_zero", {disp_out, refined, row_out, col_out}, 0);
      end
    end
  end

  initial begin
    int lo, mid, hi, d, ed, er;
    rst = 1'b1; en = 1'b0;
    cost_lo = '0; cost_mid = '0; cost_hi = '0; pos_in = '0; row_in = '0; col_in = '0;
    repeat (3) @(posedge clk);
    #1;
    check("reset_valid", valid, 0);
    check("reset_outputs", {disp_out, refined, row_out, col_out}, 0);
    rst = 1'b0;
    mon_on = 1'b1;

    // Directed vectors with hand-computed results.
    send(10, 2, 10, 20, 1, 2, 320, 1);     // symmetric -> integer
    idle(8);
    send(20, 4, 12, 5, 3, 4, 82, 1);       // +2/16
    send(12, 4, 20, 5, 5, 6, 78, 1);       // -2/16 mirror
    send(10, 2, 10, 0, 7, 8, 0, 0);        // d=0 fallback
    send(10, 2, 10, 63, 9, 10, 1008, 0);   // d=MAX_DISP-1 fallback
    send(7, 7, 7, 9, 11, 12, 144, 0);      // den=0 fallback
    send(30, 10, 0, 10, 13, 14, 168, 1);   // saturation
    send(9, 2, 0, 30, 15, 16, 488, 1);     // q=14 clamped to 8
    send(20, 4, 12, 62, 17, 18, 994, 1);   // highest refinable d
    send(12, 4, 20, 1, 19, 20, 14, 1);     // lowest refinable d
    send(5, 9, 5, 40, 21, 22, 640, 0);     // inverted parabola
    drain();

    // Random stream with 50% enable gaps.
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 1) == 1) begin
        lo = int'($urandom_range(0, 255));
        hi = int'($urandom_range(0, 255));
        mid = ($urandom_range(0, 3) != 0) ? int'($urandom_range(0, (lo < hi) ? lo : hi))
                                          : int'($urandom_range(0, 255));
        d  = int'($urandom_range(0, 63));
        ed = model(lo, mid, hi, d, er);
        send(lo, mid, hi, d, i, 1023 - i, ed, er);
      end else begin
        idle(1);
      end
    end
    drain();

    // Mid-stream reset with four samples in flight.
    send(20, 4, 12, 5, 100, 101, 82, 1);
    send(20, 4, 12, 6, 102, 103, 98, 1);
    send(20, 4, 12, 7, 104, 105, 114, 1);
    send(20, 4, 12, 8, 106, 107, 130, 1);
    @(posedge clk); #1;
    en = 1'b0; rst = 1'b1;
    sb.delete();
    @(posedge clk); #1;
    rst = 1'b0;
    idle(10);
    send(30, 10, 0, 10, 200, 201, 168, 1);
    drain();
    idle(3);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
